// File: rtl/vx_tex_dcr.sv
// Texture DCR bank: per-stage config, read 1 cycle after stage_in, writes never stall.
// Optional TEX_DCR_SHADOW_EN stages field writes in shadow sets until a COMMIT write.
package vx_tex_pkg;
  localparam int TEX_STAGE_BITS  = 3;
  localparam int TEX_LOD_MAX     = 11;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_MIPOFF_BITS = 25;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_FILTER_BITS = 1;

  typedef struct packed {
    logic [31:0]                              baddr;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0] mipoff;
    logic [1:0][TEX_LOD_BITS-1:0]              logdims;  // [0]=u, [1]=v
    logic [1:0][TEX_WRAP_BITS-1:0]             wraps;    // [0]=u, [1]=v
    logic [TEX_FORMAT_BITS-1:0]                format;
    logic [TEX_FILTER_BITS-1:0]                filter;
  } tex_dcrs_t;
endpackage

module vx_tex_dcr
  import vx_tex_pkg::*;
#(
  parameter int          NUM_STAGES = 2,
  parameter logic [11:0] BASE_ADDR  = 12'h010
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dcr_write_valid,
  input  logic [11:0]               dcr_write_addr,
  input  logic [31:0]               dcr_write_data,
  input  logic [TEX_STAGE_BITS-1:0] stage_in,
  output tex_dcrs_t                 tex_dcrs,
  output logic                      dcr_pending
);

  localparam logic [11:0] OFF_STAGE  = 12'd0;
  localparam logic [11:0] OFF_COMMIT = 12'd6;
  localparam logic [11:0] OFF_MIP    = 12'd7;
  localparam logic [11:0] OFF_END    = 12'(7 + TEX_LOD_MAX + 1);

  function automatic tex_dcrs_t f_apply(input tex_dcrs_t cur, input logic [11:0] off,
                                        input logic [31:0] d);
    tex_dcrs_t r;
    r = cur;
    case (off)
      12'd1: r.baddr = d;
      12'd2: begin
        r.logdims[0] = d[TEX_LOD_BITS-1:0];
        r.logdims[1] = d[16 +: TEX_LOD_BITS];
      end
      12'd3: r.format = d[TEX_FORMAT_BITS-1:0];
      12'd4: r.filter = d[TEX_FILTER_BITS-1:0];
      12'd5: begin
        r.wraps[0] = d[1:0];
        r.wraps[1] = d[17:16];
      end
      default: begin
        for (int l = 0; l <= TEX_LOD_MAX; l++) begin
          if (off == OFF_MIP + 12'(l)) r.mipoff[l] = d[TEX_MIPOFF_BITS-1:0];
        end
      end
    endcase
    return r;
  endfunction

  // Out-of-map addresses (including those below BASE_ADDR) wrap to offsets >= OFF_END.
  logic [11:0] w_off;
  logic        w_hit;
  logic        w_stage_wr;
  logic        w_field_wr;
  logic        w_ptr_ok;
  tex_dcrs_t   w_rd_sel;

  assign w_off      = dcr_write_addr - BASE_ADDR;
  assign w_hit      = dcr_write_valid && (w_off < OFF_END);
  assign w_stage_wr = w_hit && (w_off == OFF_STAGE);
  assign w_field_wr = w_hit && (w_off != OFF_STAGE) && (w_off != OFF_COMMIT);
  assign w_ptr_ok   = 32'(dcr_write_data[TEX_STAGE_BITS-1:0]) < NUM_STAGES;

  tex_dcrs_t                 r_active [NUM_STAGES];
  logic [TEX_STAGE_BITS-1:0] r_wptr;
  tex_dcrs_t                 r_rd;

  // Stages beyond NUM_STAGES match no entry and read back as zero.
  always_comb begin
    w_rd_sel = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (stage_in == TEX_STAGE_BITS'(s)) w_rd_sel = r_active[s];
    end
  end

`ifdef TEX_DCR_SHADOW_EN
  logic                  w_commit_wr;
  tex_dcrs_t             r_shadow [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_dirty;

  assign w_commit_wr = w_hit && (w_off == OFF_COMMIT);
  assign dcr_pending = |r_dirty;
`else
  assign dcr_pending = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rd   <= '0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        r_active[s] <= '0;
`ifdef TEX_DCR_SHADOW_EN
        r_shadow[s] <= '0;
`endif
      end
`ifdef TEX_DCR_SHADOW_EN
      r_dirty <= '0;
`endif
    end else begin
      r_rd <= w_rd_sel;
      if (w_stage_wr && w_ptr_ok) r_wptr <= dcr_write_data[TEX_STAGE_BITS-1:0];
`ifdef TEX_DCR_SHADOW_EN
      if (w_commit_wr) r_dirty <= '0;
`endif
      for (int s = 0; s < NUM_STAGES; s++) begin
`ifdef TEX_DCR_SHADOW_EN
        if (w_field_wr && (r_wptr == TEX_STAGE_BITS'(s))) begin
          r_shadow[s] <= f_apply(r_shadow[s], w_off, dcr_write_data);
          r_dirty[s]  <= 1'b1;
        end
        if (w_commit_wr && r_dirty[s]) r_active[s] <= r_shadow[s];
`else
        if (w_field_wr && (r_wptr == TEX_STAGE_BITS'(s)))
          r_active[s] <= f_apply(r_active[s], w_off, dcr_write_data);
`endif
      end
    end
  end

  assign tex_dcrs = r_rd;

endmodule
